// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH itself after the final shift.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a ^ b ^ bin, borrow-out when a < b + bin.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock with valid/ready on both sides.
// Optional SERIAL_SUBTRACTOR_SAT_EN clamps the difference to zero when the final borrow is set.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output state_e           state_o
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready_o is high only in ST_IDLE and out_valid_o only in ST_DONE, so they never overlap.

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_diff_sel;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             w_d;
  logic             w_bo;

  full_subtractor u_cell (
    .a_i    (r_a_sr[0]),
    .b_i    (r_b_sr[0]),
    .bin_i  (r_borrow),
    .diff_o (w_d),
    .bout_o (w_bo)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid_i)        w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
      ST_DONE:  if (out_ready_i)       w_next_state = ST_IDLE;
      default:                         w_next_state = ST_IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
  always_comb begin
    w_res_next            = r_res_sr >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_a_sr   <= a_i;
            r_b_sr   <= b_i;
            r_borrow <= bin_i;
            r_cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  assign w_diff_sel = r_borrow ? '0 : r_res_sr;
`else
  assign w_diff_sel = r_res_sr;
`endif

  always_comb begin
    in_ready_o  = (r_state == ST_IDLE);
    out_valid_o = (r_state == ST_DONE);
    busy_o      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    diff_o      = out_valid_o ? w_diff_sel : '0;
    bout_o      = out_valid_o ? r_borrow : 1'b0;
    state_o     = r_state;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor at WIDTH=8 (optionally with SERIAL_SUBTRACTOR_SAT_EN).
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  state_e       dbg_state;

  logic [W:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_edge = 0;
  bit prev_valid = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .a_i         (a),
    .b_i         (b),
    .bin_i       (bin),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .diff_o      (diff),
    .bout_o      (bout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .state_o     (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] sat_fix(input logic [W-1:0] d, input logic bo);
    return (SAT && bo) ? '0 : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- driver ----
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                      input logic [W-1:0] exp_d, input logic exp_b, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_wait_ready: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    a = av; b = bv; bin = binv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc_cyc = cyc;
    if (push) exp_q.push_back({exp_d, exp_b});
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: out_valid not seen within %0d cycles, required 1", name, n);
    end
  endtask

  // ---- monitor / scoreboard ----
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        checks++;
        if (cyc - acc_cyc != W) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d", cyc - acc_cyc, W);
        end
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        logic [W:0] e;
        checks++;
        hs_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got diff=0x%0h bout=%0b expected no result", diff, bout);
        end else begin
          e = exp_q.pop_front();
          if ({diff, bout} !== e) begin
            errors++;
            $display("FAIL result: got diff=0x%0h bout=%0b expected diff=0x%0h bout=%0b",
                     diff, bout, e[W:1], e[0]);
          end
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int n;
    int accepted;
    bit rdy;
    reset_n = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy",      busy,      0);
    check("reset_diff",      diff,      0);
    check("reset_bout",      bout,      0);
    reset_n = 1'b1;
    tick();

    // basic vectors
    send(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1);
    send(8'h00, 8'h01, 1'b0, sat_fix(8'hFF, 1'b1), 1'b1, 1);
    send(8'hFF, 8'hFF, 1'b1, sat_fix(8'hFF, 1'b1), 1'b1, 1);
    send(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1);
    send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1);
    send(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1);
    wait_out_valid("basic_drain");
    tick(); tick();

    // consumer stall in ST_DONE, with an ignored input pulse
    out_ready = 1'b0;
    send(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1);
    wait_out_valid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      check("stall_diff",     diff,     8'h64);
      check("stall_bout",     bout,     0);
      check("stall_in_ready", in_ready, 0);
      if (i == 2) begin
        a = 8'h01; b = 8'h02; bin = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_back_idle", in_ready, 1);

    // reset on the 3rd ST_SHIFT cycle
    send(8'h33, 8'h11, 1'b0, 8'h00, 1'b0, 0);
    tick();
    tick();
    check("abort_state_shift", dbg_state, ST_SHIFT);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy",      busy,      0);
    check("abort_in_ready",  in_ready,  1);
    check("abort_diff",      diff,      0);
    check("abort_bout",      bout,      0);
    tick();
    reset_n = 1'b1;
    tick();
    send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1);
    wait_out_valid("after_reset_wait");
    tick(); tick();

    // back-to-back with in_valid held high
    out_ready = 1'b1;
    a = 8'h37; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
    n = 0; accepted = 0;
    while (accepted < 2 && n < 100) begin
      rdy = in_ready;
      tick();
      n++;
      if (rdy) begin
        accepted++;
        acc_cyc = cyc;
        if (accepted == 1) begin
          exp_q.push_back({8'h25, 1'b0});
          a = 8'h12; b = 8'h37; bin = 1'b1;
        end else begin
          exp_q.push_back({sat_fix(8'hDA, 1'b1), 1'b1});
          in_valid = 1'b0;
          check("b2b_accept_gap", cyc - hs_edge, 1);
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", accepted, 2);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
